// File: rtl/regbank_wb_scheduler_if.sv
// Writeback scheduler bus: ALU/LDR requesters, bank write port,
// issue-stage hazard check and scoreboard status.
interface regbank_wb_scheduler_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
);
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_dest;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;
  logic                ldr_valid;
  logic [ADDR_W-1:0]   ldr_dest;
  logic [DATA_W-1:0]   ldr_data;
  logic                ldr_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_dest;
  logic [DATA_W-1:0]   wr_data;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_dest;
  logic [ADDR_W-1:0]   issue_src1;
  logic [ADDR_W-1:0]   issue_src2;
  logic                issue_stall;
  logic [NUM_REGS-1:0] pending;
  logic                wb_err;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ldr_valid, ldr_dest, ldr_data,
    output issue_valid, issue_dest,
    output issue_src1, issue_src2,
    input  alu_ready, ldr_ready,
    input  wr_en, wr_dest, wr_data,
    input  issue_stall, pending, wb_err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ldr_valid, ldr_dest, ldr_data,
    input  issue_valid, issue_dest,
    input  issue_src1, issue_src2,
    output alu_ready, ldr_ready,
    output wr_en, wr_dest, wr_data,
    output issue_stall, pending, wb_err
  );
endinterface

// File: rtl/regbank_wb_scheduler.sv
// Round-robin ALU/LDR writeback arbiter driving the register bank
// write port, plus a per-register pending scoreboard for issue stalls.
module regbank_wb_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  regbank_wb_scheduler_if.slave bus
);

  logic                last_grant;
  logic                alu_gnt;
  logic                ldr_gnt;
  logic                acc;
  logic [ADDR_W-1:0]   acc_dest;
  logic [DATA_W-1:0]   acc_data;
  logic                hazard;
  logic                issue_acc;
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_dest_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                err_q;
  logic                err_d;

  always_comb begin
    alu_gnt = rst_n && bus.alu_valid
            && (!bus.ldr_valid || last_grant);
    ldr_gnt = rst_n && bus.ldr_valid
            && (!bus.alu_valid || !last_grant);
    acc      = alu_gnt || ldr_gnt;
    acc_dest = alu_gnt ? bus.alu_dest : bus.ldr_dest;
    acc_data = alu_gnt ? bus.alu_data : bus.ldr_data;

    // Registered pending only: a committing write does not unstall.
    hazard = pend_q[bus.issue_src1]
           | pend_q[bus.issue_src2]
           | pend_q[bus.issue_dest];
    issue_acc = rst_n && bus.issue_valid && !hazard;

    set_mask = '0;
    clr_mask = '0;
    if (issue_acc) set_mask[bus.issue_dest] = 1'b1;
    if (wr_en_q)   clr_mask[wr_dest_q]      = 1'b1;
    // Set applied last so it wins a same-register collision.
    pend_d = (pend_q & ~clr_mask) | set_mask;

    err_d = err_q | (acc && !pend_q[acc_dest]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_dest_q  <= '0;
      wr_data_q  <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= acc;
      if (acc) begin
        wr_dest_q  <= acc_dest;
        wr_data_q  <= acc_data;
        last_grant <= ldr_gnt;
      end
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign bus.alu_ready   = alu_gnt;
  assign bus.ldr_ready   = ldr_gnt;
  assign bus.issue_stall = rst_n && bus.issue_valid && hazard;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_dest     = wr_dest_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.pending     = pend_q;
  assign bus.wb_err      = err_q;

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// Cycle-by-cycle vector table for the writeback scheduler,
// plus hand sequences for reset behaviour.
module tb_regbank_wb_scheduler;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  regbank_wb_scheduler_if #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(16)
  ) bus ();

  regbank_wb_scheduler #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;
    logic [3:0]  ad;
    logic [31:0] adt;
    logic        lv;
    logic [3:0]  ld;
    logic [31:0] ldt;
    logic        iv;
    logic [3:0]  id;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [2:0]  ecomb;
    logic        ewe;
    logic [3:0]  ewd;
    logic [31:0] ewdt;
    logic [15:0] ep;
    logic        eerr;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] regs_now();
    return {9'd0, bus.wr_en, bus.wr_dest, bus.wr_data,
            bus.pending, bus.wb_err};
  endfunction

  function automatic logic [63:0] comb_now();
    return {61'd0, bus.alu_ready, bus.ldr_ready, bus.issue_stall};
  endfunction

  task automatic drive(input vec_t v);
    bus.alu_valid   = v.av;
    bus.alu_dest    = v.ad;
    bus.alu_data    = v.adt;
    bus.ldr_valid   = v.lv;
    bus.ldr_dest    = v.ld;
    bus.ldr_data    = v.ldt;
    bus.issue_valid = v.iv;
    bus.issue_dest  = v.id;
    bus.issue_src1  = v.s1;
    bus.issue_src2  = v.s2;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    // fields: alu v/d/data, ldr v/d/data, issue v/dest/s1/s2,
    // {alu_ready,ldr_ready,stall}, then wr_en/dest/data, pending, err
    tbl[0]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd0,32'h0,16'h0000,1'b0};
    tbl[1]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd3,4'd0,4'd0,
                3'b000,1'b0,4'd0,32'h0,16'h0008,1'b0};
    tbl[2]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd1,4'd0,4'd0,
                3'b000,1'b0,4'd0,32'h0,16'h000A,1'b0};
    tbl[3]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd2,4'd0,4'd0,
                3'b000,1'b0,4'd0,32'h0,16'h000E,1'b0};
    tbl[4]  = '{1'b1,4'd1,32'h11,1'b1,4'd2,32'h22,1'b0,4'd0,4'd0,4'd0,
                3'b100,1'b1,4'd1,32'h11,16'h000E,1'b0};
    tbl[5]  = '{1'b0,4'd0,32'h0,1'b1,4'd2,32'h22,1'b0,4'd0,4'd0,4'd0,
                3'b010,1'b1,4'd2,32'h22,16'h000C,1'b0};
    tbl[6]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd2,32'h22,16'h0008,1'b0};
    tbl[7]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd5,4'd0,4'd0,
                3'b000,1'b0,4'd2,32'h22,16'h0028,1'b0};
    tbl[8]  = '{1'b1,4'd5,32'hDEADBEEF,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,
                4'd0,3'b100,1'b1,4'd5,32'hDEADBEEF,16'h0028,1'b0};
    tbl[9]  = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd5,32'hDEADBEEF,16'h0008,1'b0};
    tbl[10] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd6,4'd0,4'd0,
                3'b000,1'b0,4'd5,32'hDEADBEEF,16'h0048,1'b0};
    tbl[11] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd10,4'd0,4'd0,
                3'b000,1'b0,4'd5,32'hDEADBEEF,16'h0448,1'b0};
    tbl[12] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd11,4'd0,4'd0,
                3'b000,1'b0,4'd5,32'hDEADBEEF,16'h0C48,1'b0};
    tbl[13] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd12,4'd0,4'd0,
                3'b000,1'b0,4'd5,32'hDEADBEEF,16'h1C48,1'b0};
    tbl[14] = '{1'b1,4'd6,32'hA6,1'b1,4'd11,32'hB11,1'b0,4'd0,4'd0,4'd0,
                3'b010,1'b1,4'd11,32'hB11,16'h1C48,1'b0};
    tbl[15] = '{1'b1,4'd6,32'hA6,1'b1,4'd12,32'hB12,1'b0,4'd0,4'd0,4'd0,
                3'b100,1'b1,4'd6,32'hA6,16'h1448,1'b0};
    tbl[16] = '{1'b1,4'd10,32'hA10,1'b1,4'd12,32'hB12,1'b0,4'd0,4'd0,
                4'd0,3'b010,1'b1,4'd12,32'hB12,16'h1408,1'b0};
    tbl[17] = '{1'b1,4'd10,32'hA10,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b100,1'b1,4'd10,32'hA10,16'h0408,1'b0};
    tbl[18] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd10,32'hA10,16'h0008,1'b0};
    tbl[19] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd4,4'd0,4'd0,
                3'b000,1'b0,4'd10,32'hA10,16'h0018,1'b0};
    tbl[20] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd8,4'd4,4'd0,
                3'b001,1'b0,4'd10,32'hA10,16'h0018,1'b0};
    tbl[21] = '{1'b1,4'd4,32'h44,1'b0,4'd0,32'h0,1'b1,4'd8,4'd4,4'd0,
                3'b101,1'b1,4'd4,32'h44,16'h0018,1'b0};
    tbl[22] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd8,4'd4,4'd0,
                3'b001,1'b0,4'd4,32'h44,16'h0008,1'b0};
    tbl[23] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd8,4'd4,4'd0,
                3'b000,1'b0,4'd4,32'h44,16'h0108,1'b0};
    tbl[24] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd8,4'd0,4'd0,
                3'b001,1'b0,4'd4,32'h44,16'h0108,1'b0};
    tbl[25] = '{1'b0,4'd0,32'h0,1'b1,4'd9,32'h99,1'b0,4'd0,4'd0,4'd0,
                3'b010,1'b1,4'd9,32'h99,16'h0108,1'b1};
    tbl[26] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd9,32'h99,16'h0108,1'b1};
    tbl[27] = '{1'b1,4'd7,32'h77,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b100,1'b1,4'd7,32'h77,16'h0108,1'b1};
    tbl[28] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd7,4'd0,4'd0,
                3'b000,1'b0,4'd7,32'h77,16'h0188,1'b1};
    tbl[29] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b000,1'b0,4'd7,32'h77,16'h0188,1'b1};
    tbl[30] = '{1'b1,4'd8,32'h88,1'b0,4'd0,32'h0,1'b0,4'd0,4'd0,4'd0,
                3'b100,1'b1,4'd8,32'h88,16'h0188,1'b1};
    tbl[31] = '{1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,1'b1,4'd9,4'd0,4'd0,
                3'b000,1'b0,4'd8,32'h88,16'h0288,1'b1};

    // Reset held with requests asserted: nothing may be accepted.
    rst_n = 1'b0;
    drive(tbl[0]);
    bus.alu_valid   = 1'b1;
    bus.ldr_valid   = 1'b1;
    bus.issue_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_reset_comb", comb_now(), 64'd0);
    chk("in_reset_regs", regs_now(), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("v%0d_comb", i), comb_now(),
          {61'd0, tbl[i].ecomb});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regs", i), regs_now(),
          {9'd0, tbl[i].ewe, tbl[i].ewd, tbl[i].ewdt,
           tbl[i].ep, tbl[i].eerr});
      @(negedge clk);
    end

    // Async reset while a write is on the port.
    drive(tbl[0]);
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 4'd3;
    bus.alu_data  = 32'h33;
    @(posedge clk);
    #1;
    chk("pre_rst_write", regs_now(),
        {9'd0, 1'b1, 4'd3, 32'h33, 16'h0288, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_regs", regs_now(), 64'd0);
    chk("async_rst_comb", comb_now(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // last_grant back at reset value: ALU wins the first tie.
    bus.ldr_valid = 1'b1;
    bus.ldr_dest  = 4'd4;
    bus.ldr_data  = 32'h44;
    #2;
    chk("post_rst_tie", comb_now(), 64'b100);
    @(negedge clk);
    drive(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
